// File: rtl/vproc_pkg.sv
// Shared vector-unit types: vtype encodings and field layouts.
package vproc_pkg;

  localparam int unsigned ELEN = 32;

  typedef enum logic [2:0] {
    VSEW_8  = 3'd0,
    VSEW_16 = 3'd1,
    VSEW_32 = 3'd2,
    VSEW_64 = 3'd3
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  localparam logic [2:0] VLMUL_RSVD = 3'd4;

  // Raw 32-bit vtype operand as delivered with vsetvl*
  typedef struct packed {
    logic [23:0] rsvd;
    logic        vma;
    logic        vta;
    vsew_e       vsew;
    vlmul_e      vlmul;
  } vtype_raw_t;

  // Architectural vtype register
  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vsew_e  vsew;
    vlmul_e vlmul;
  } vtype_t;

  localparam vtype_t VTYPE_RST = '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: VSEW_8, vlmul: LMUL_1};

endpackage

// File: rtl/vproc_vlmax.sv
// Combinational VLMAX for a given SEW/LMUL; flags illegal encodings.
module vproc_vlmax
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  output logic [VL_W-1:0] vlmax,
  output logic            vill
);

  logic [VL_W-1:0] base;

  always_comb begin
    base = VL_W'(VREG_W / 8) >> vsew;
    if (!vlmul[2]) begin
      vlmax = base << vlmul[1:0];
    end else begin
      // Fractional LMUL 7/6/5 -> shift right by 1/2/3 (two's complement of vlmul)
      vlmax = base >> (3'd0 - vlmul);
    end
    vill = (vsew > VSEW_32) || (vlmul == VLMUL_RSVD) || (vlmax == '0);
  end

endmodule

// File: rtl/vproc_vcfg.sv
// vsetvl/vsetvli/vsetivli execution: latch request, compute vl/vtype, commit when result stage is free.
module vproc_vcfg
  import vproc_pkg::*;
#(
  parameter int unsigned XIF_ID_W = 3,
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned VL_W     = $clog2(VREG_W) + 1
) (
  input  logic                clk_i,
  input  logic                sync_rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [XIF_ID_W-1:0] cfg_id_i,
  input  logic [4:0]          cfg_rd_i,
  input  logic [31:0]         cfg_avl_i,
  input  logic [31:0]         cfg_vtype_i,
  input  logic                cfg_keep_vl_i,
  input  logic                cfg_vlmax_i,
  output logic                result_vl_valid_o,
  input  logic                result_vl_ready_i,
  output logic [XIF_ID_W-1:0] result_vl_id_o,
  output logic [4:0]          result_vl_addr_o,
  output logic [31:0]         result_vl_data_o,
  output logic [VL_W-1:0]     vl_o,
  output logic [2:0]          vsew_o,
  output logic [2:0]          vlmul_o,
  output logic                vta_o,
  output logic                vma_o,
  output logic                vill_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   accept, calc_en, commit;

  logic [XIF_ID_W-1:0] req_id_q;
  logic [4:0]          req_rd_q;
  logic [31:0]         req_avl_q;
  vtype_raw_t          req_vtype_q;
  logic                req_keep_q, req_vlmax_q;

  logic [VL_W-1:0] pend_vl_q, calc_vl;
  vtype_t          pend_vtype_q, calc_vtype;
  logic [VL_W-1:0] vl_q;
  vtype_t          vtype_q;

  logic [VL_W-1:0] vlmax;
  logic            vlmax_vill, calc_vill;

  // State register
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; a reset cycle never issues a commit pulse
  always_comb begin
    state_d           = state_q;
    cfg_ready_o       = 1'b0;
    busy_o            = 1'b1;
    accept            = 1'b0;
    calc_en           = 1'b0;
    commit            = 1'b0;
    result_vl_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        state_d = COMMIT;
      end
      COMMIT: begin
        if (result_vl_ready_i && sync_rst_ni) begin
          commit            = 1'b1;
          result_vl_valid_o = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  vproc_vlmax #(
    .VREG_W (VREG_W),
    .VL_W   (VL_W)
  ) u_vlmax (
    .vsew  (req_vtype_q.vsew),
    .vlmul (req_vtype_q.vlmul),
    .vlmax (vlmax),
    .vill  (vlmax_vill)
  );

  // New vl/vtype from the latched request
  always_comb begin
    calc_vill = vlmax_vill || (|req_vtype_q.rsvd);
    calc_vl   = vlmax;
    if (req_keep_q) begin
      if (vl_q < vlmax) calc_vl = vl_q;
    end else if (!req_vlmax_q) begin
      if (req_avl_q < 32'(vlmax)) calc_vl = VL_W'(req_avl_q);
    end
    calc_vtype = '{vill: 1'b0, vma: req_vtype_q.vma, vta: req_vtype_q.vta,
                   vsew: req_vtype_q.vsew, vlmul: req_vtype_q.vlmul};
    if (calc_vill) begin
      calc_vl    = '0;
      calc_vtype = VTYPE_RST;
    end
  end

  // Request and pending registers need no reset: only read after being loaded
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_id_q    <= cfg_id_i;
      req_rd_q    <= cfg_rd_i;
      req_avl_q   <= cfg_avl_i;
      req_vtype_q <= vtype_raw_t'(cfg_vtype_i);
      req_keep_q  <= cfg_keep_vl_i;
      req_vlmax_q <= cfg_vlmax_i;
    end
    if (calc_en) begin
      pend_vl_q    <= calc_vl;
      pend_vtype_q <= calc_vtype;
    end
  end

  // Architectural vl/vtype
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      vl_q    <= '0;
      vtype_q <= VTYPE_RST;
    end else if (commit) begin
      vl_q    <= pend_vl_q;
      vtype_q <= pend_vtype_q;
    end
  end

  assign result_vl_id_o   = req_id_q;
  assign result_vl_addr_o = req_rd_q;
  assign result_vl_data_o = 32'(vl_q);
  assign vl_o             = vl_q;
  assign vsew_o           = vtype_q.vsew;
  assign vlmul_o          = vtype_q.vlmul;
  assign vta_o            = vtype_q.vta;
  assign vma_o            = vtype_q.vma;
  assign vill_o           = vtype_q.vill;

endmodule

// File: tb/tb_vproc_vcfg.sv
// Bench for vproc_vcfg: transaction-level reference model compared every cycle, directed and random traffic.
module tb_vproc_vcfg;

  localparam int unsigned XIF_ID_W = 3;
  localparam int unsigned VREG_W   = 128;
  localparam int unsigned VL_W     = $clog2(VREG_W) + 1;

  logic                clk_i = 1'b0;
  logic                sync_rst_ni;
  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [XIF_ID_W-1:0] cfg_id_i;
  logic [4:0]          cfg_rd_i;
  logic [31:0]         cfg_avl_i;
  logic [31:0]         cfg_vtype_i;
  logic                cfg_keep_vl_i;
  logic                cfg_vlmax_i;
  logic                result_vl_valid_o;
  logic                result_vl_ready_i;
  logic [XIF_ID_W-1:0] result_vl_id_o;
  logic [4:0]          result_vl_addr_o;
  logic [31:0]         result_vl_data_o;
  logic [VL_W-1:0]     vl_o;
  logic [2:0]          vsew_o, vlmul_o;
  logic                vta_o, vma_o, vill_o, busy_o;

  vproc_vcfg #(.XIF_ID_W(XIF_ID_W), .VREG_W(VREG_W), .VL_W(VL_W)) dut (
    .clk_i             (clk_i),
    .sync_rst_ni       (sync_rst_ni),
    .cfg_valid_i       (cfg_valid_i),
    .cfg_ready_o       (cfg_ready_o),
    .cfg_id_i          (cfg_id_i),
    .cfg_rd_i          (cfg_rd_i),
    .cfg_avl_i         (cfg_avl_i),
    .cfg_vtype_i       (cfg_vtype_i),
    .cfg_keep_vl_i     (cfg_keep_vl_i),
    .cfg_vlmax_i       (cfg_vlmax_i),
    .result_vl_valid_o (result_vl_valid_o),
    .result_vl_ready_i (result_vl_ready_i),
    .result_vl_id_o    (result_vl_id_o),
    .result_vl_addr_o  (result_vl_addr_o),
    .result_vl_data_o  (result_vl_data_o),
    .vl_o              (vl_o),
    .vsew_o            (vsew_o),
    .vlmul_o           (vlmul_o),
    .vta_o             (vta_o),
    .vma_o             (vma_o),
    .vill_o            (vill_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulses = 0;
  int last_acc_cyc = 0;
  bit rnd_ready = 0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // VLMAX = VLEN * LMUL / SEW, with LMUL possibly fractional
  function automatic int ref_vlmax(input int sew, input int lmul);
    int sew_bits, num, den;
    sew_bits = 8 << sew;
    num = 1;
    den = 1;
    if (lmul < 4) num = 1 << lmul;
    else          den = 1 << (8 - lmul);
    return (VREG_W * num) / (den * sew_bits);
  endfunction

  // Reference model: architectural vtype/vl plus one outstanding request
  bit          m_init = 0;
  bit          m_busy = 0;
  int          m_age  = 0;
  logic [31:0] m_vl;
  logic        m_vill, m_vma, m_vta;
  logic [2:0]  m_vsew, m_vlmul;
  logic [2:0]  p_id;
  logic [4:0]  p_rd;
  logic [31:0] p_vl;
  logic        p_vill, p_vma, p_vta;
  logic [2:0]  p_vsew, p_vlmul;

  always @(negedge clk_i) begin
    logic        exp_valid;
    int          sew, lmul, vmax;
    logic [31:0] vmax32;
    bit          ill;
    if (m_init) begin
      exp_valid = m_busy && (m_age >= 2) && result_vl_ready_i && sync_rst_ni;
      check("cfg_ready", 32'(cfg_ready_o), 32'(!m_busy));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("vl_valid", 32'(result_vl_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check("vl_id", 32'(result_vl_id_o), 32'(p_id));
        check("vl_addr", 32'(result_vl_addr_o), 32'(p_rd));
      end
      check("vl", 32'(vl_o), m_vl);
      check("vl_data", result_vl_data_o, m_vl);
      check("vill", 32'(vill_o), 32'(m_vill));
      check("vtype_fields", {24'd0, vma_o, vta_o, vsew_o, vlmul_o}, {24'd0, m_vma, m_vta, m_vsew, m_vlmul});
    end
    if (result_vl_valid_o === 1'b1) pulses++;

    if (!sync_rst_ni) begin
      m_init = 1; m_busy = 0; m_vl = 0;
      m_vill = 1; m_vma = 0; m_vta = 0; m_vsew = 0; m_vlmul = 0;
    end else if (m_busy) begin
      if (m_age >= 2 && result_vl_ready_i) begin
        m_busy = 0;
        m_vl = p_vl; m_vill = p_vill; m_vma = p_vma; m_vta = p_vta;
        m_vsew = p_vsew; m_vlmul = p_vlmul;
      end else begin
        m_age++;
      end
    end else if (cfg_valid_i) begin
      sew  = int'(cfg_vtype_i[5:3]);
      lmul = int'(cfg_vtype_i[2:0]);
      vmax = ref_vlmax(sew, lmul);
      vmax32 = 32'(vmax);
      ill = (cfg_vtype_i[31:8] != 0) || (sew > 2) || (lmul == 4) || (vmax == 0);
      p_id = cfg_id_i;
      p_rd = cfg_rd_i;
      if (ill) begin
        p_vl = 0; p_vill = 1; p_vma = 0; p_vta = 0; p_vsew = 0; p_vlmul = 0;
      end else begin
        if (cfg_keep_vl_i)    p_vl = (m_vl < vmax32) ? m_vl : vmax32;
        else if (cfg_vlmax_i) p_vl = vmax32;
        else                  p_vl = (cfg_avl_i < vmax32) ? cfg_avl_i : vmax32;
        p_vill = 0; p_vma = cfg_vtype_i[7]; p_vta = cfg_vtype_i[6];
        p_vsew = cfg_vtype_i[5:3]; p_vlmul = cfg_vtype_i[2:0];
      end
      m_busy = 1;
      m_age  = 1;
    end
  end

  // Randomised result-stage backpressure
  always @(posedge clk_i) begin
    if (rnd_ready) begin
      #1;
      result_vl_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a request and hold it until the unit takes it
  task automatic send(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] avl,
                      input logic [31:0] vtype, input logic keep, input logic vmax);
    logic acc;
    acc = 1'b0;
    cfg_id_i = id; cfg_rd_i = rd; cfg_avl_i = avl; cfg_vtype_i = vtype;
    cfg_keep_vl_i = keep; cfg_vlmax_i = vmax; cfg_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      acc = cfg_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: request id %0d not accepted within 200 cycles", id);
    end
    last_acc_cyc = cyc;
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: unit still busy after 200 cycles");
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, acc1;
    sync_rst_ni = 1'b0; cfg_valid_i = 1'b0; result_vl_ready_i = 1'b1;
    cfg_id_i = '0; cfg_rd_i = '0; cfg_avl_i = '0; cfg_vtype_i = '0;
    cfg_keep_vl_i = 1'b0; cfg_vlmax_i = 1'b0;

    check("ref_e8m8", 32'(ref_vlmax(0, 3)), 32'd128);
    check("ref_e8mf2", 32'(ref_vlmax(0, 7)), 32'd8);
    check("ref_e32mf8", 32'(ref_vlmax(2, 5)), 32'd0);
    check("ref_e32m1", 32'(ref_vlmax(2, 0)), 32'd4);

    repeat (2) @(posedge clk_i);
    #1 sync_rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_vill", 32'(vill_o), 32'd1);
    check("rst_vl", 32'(vl_o), 32'd0);
    check("rst_ready", 32'(cfg_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // 0x10 encodes SEW32/LMUL1: VLMAX 4, avl 10 clamps to 4
    send(3'd1, 5'd5, 32'd10, 32'h10, 1'b0, 1'b0);
    @(negedge clk_i);
    check("lat_calc_nopulse", 32'(result_vl_valid_o), 32'd0);
    @(negedge clk_i);
    check("lat_pulse", 32'(result_vl_valid_o), 32'd1);
    check("lat_vl_old", 32'(vl_o), 32'd0);
    @(negedge clk_i);
    check("lat_vl_new", 32'(vl_o), 32'd4);
    check("lat_data_new", result_vl_data_o, 32'd4);
    @(posedge clk_i); #1;

    send(3'd2, 5'd6, 32'd0, 32'h03, 1'b0, 1'b1);
    wait_idle();
    @(negedge clk_i); check("vlmax_e8m8", 32'(vl_o), 32'd128);
    @(posedge clk_i); #1;
    send(3'd3, 5'd7, 32'd100, 32'h07, 1'b0, 1'b0);
    wait_idle();
    @(negedge clk_i); check("avl_e8mf2", 32'(vl_o), 32'd8);
    @(posedge clk_i); #1;

    send(3'd4, 5'd1, 32'd50, 32'h15, 1'b0, 1'b0);
    wait_idle();
    @(negedge clk_i);
    check("vill_e32mf8", 32'(vill_o), 32'd1);
    check("vill_e32mf8_vl", 32'(vl_o), 32'd0);
    @(posedge clk_i); #1;
    send(3'd5, 5'd2, 32'd5, 32'h00, 1'b0, 1'b0);
    wait_idle();
    send(3'd5, 5'd2, 32'd5, 32'h100, 1'b0, 1'b0);
    wait_idle();
    @(negedge clk_i); check("vill_rsvd", 32'(vill_o), 32'd1);
    @(posedge clk_i); #1;

    // Backpressure: five stalled COMMIT cycles, pulse on the sixth
    result_vl_ready_i = 1'b0;
    p0 = pulses;
    send(3'd6, 5'd9, 32'd3, 32'h10, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_nopulse", 32'(result_vl_valid_o), 32'd0);
      check("stall_vl_held", 32'(vl_o), 32'd0);
    end
    @(posedge clk_i); #1 result_vl_ready_i = 1'b1;
    @(negedge clk_i);
    check("stall_pulse", 32'(result_vl_valid_o), 32'd1);
    check("stall_id", 32'(result_vl_id_o), 32'd6);
    check("stall_rd", 32'(result_vl_addr_o), 32'd9);
    wait_idle();
    check("stall_one_pulse", 32'(pulses - p0), 32'd1);

    // Keep-vl with a held request: second accept three cycles after the first
    send(3'd7, 5'd3, 32'd16, 32'h00, 1'b0, 1'b0);
    acc1 = last_acc_cyc;
    send(3'd0, 5'd4, 32'd999, 32'h08, 1'b1, 1'b0);
    check("b2b_gap", 32'(last_acc_cyc - acc1), 32'd3);
    wait_idle();
    @(negedge clk_i); check("keep_vl", 32'(vl_o), 32'd8);
    @(posedge clk_i); #1;

    // Reset while waiting in COMMIT
    result_vl_ready_i = 1'b0;
    send(3'd1, 5'd1, 32'd7, 32'h10, 1'b0, 1'b0);
    p0 = pulses;
    @(posedge clk_i); #1;
    sync_rst_ni = 1'b0; result_vl_ready_i = 1'b1;
    @(negedge clk_i); check("rst_commit_nopulse", 32'(result_vl_valid_o), 32'd0);
    @(posedge clk_i); #1 sync_rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_commit_vl", 32'(vl_o), 32'd0);
    check("rst_commit_ready", 32'(cfg_ready_o), 32'd1);
    check("rst_commit_pulses", 32'(pulses - p0), 32'd0);
    @(posedge clk_i); #1;

    // Random traffic
    rnd_ready = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] vt, avl;
      int sew;
      sew = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      vt = {24'd0, 1'($urandom), 1'($urandom), 3'(sew), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 15) == 0) vt[31:8] = 24'($urandom_range(1, 255)) << $urandom_range(0, 16);
      avl = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 150));
      send(3'($urandom), 5'($urandom), avl, vt,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
    end
    wait_idle();
    rnd_ready = 0;
    result_vl_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
